// File: rtl/uart_tx_fifo.sv
//------------------------------------------------------------------------------
// uart_tx_fifo : UART transmitter with configurable frame and input FIFO
// Revision     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module uart_tx_fifo #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115_200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          din,
  input  logic                          din_valid,
  output logic                          din_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int AW           = $clog2(FIFO_DEPTH);
  localparam int IDX_W        = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);
  localparam logic [AW:0]      FULL      = (AW + 1)'(FIFO_DEPTH);
  localparam logic             ODD       = (PARITY == 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [2:0]           state;
  logic [CNT_W-1:0]     baud_cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 par_bit;
  logic [DATA_BITS-1:0] head;
  logic                 push;
  logic                 pop;
  logic                 bit_end;
  logic                 stop_done;

  assign head      = mem[rd_ptr];
  assign din_ready = (fifo_count != FULL);
  assign push      = din_valid && din_ready;
  assign bit_end   = (baud_cnt == BIT_LAST);
  assign stop_done = (state == S_STOP) && bit_end && (bit_idx == STOP_LAST);
  // A queued word starts immediately from IDLE or back-to-back after the last stop bit
  assign pop       = (fifo_count != '0) && ((state == S_IDLE) || stop_done);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + (AW + 1)'(1);
        2'b01:   fifo_count <= fifo_count - (AW + 1)'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      tx       <= 1'b1;
      busy     <= 1'b0;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      par_bit  <= 1'b0;
    end else if (pop) begin
      // Parity is captured with the word so later pushes cannot disturb it
      state    <= S_START;
      tx       <= 1'b0;
      busy     <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= head;
      par_bit  <= (^head) ^ ODD;
    end else begin
      case (state)
        S_IDLE: begin
          tx   <= 1'b1;
          busy <= 1'b0;
        end
        S_START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            state    <= S_DATA;
            tx       <= shift[0];
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == DATA_LAST) begin
              bit_idx <= '0;
              if (PARITY != 0) begin
                state <= S_PARITY;
                tx    <= par_bit;
              end else begin
                state <= S_STOP;
                tx    <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + IDX_W'(1);
              shift   <= shift >> 1;
              tx      <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        S_PARITY: begin
          if (bit_end) begin
            baud_cnt <= '0;
            state    <= S_STOP;
            tx       <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        S_STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == STOP_LAST) begin
              bit_idx <= '0;
              state   <= S_IDLE;
              busy    <= 1'b0;
            end else begin
              bit_idx <= bit_idx + IDX_W'(1);
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= S_IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter, successor to the fixed 8N1 transmitter. It adds a configurable frame format (data bits, parity, stop bits) and a configurable baud divider. A small input FIFO with a valid/ready handshake allows back-to-back frames with no idle gap. It sits between packet/counter logic and the board TX pin.

Parameters:
CLK_FREQ, 100_000_000, system clock frequency in Hz
BAUD, 115_200, line rate; CLKS_PER_BIT = CLK_FREQ/BAUD (integer division, must be >= 2; default 868)
DATA_BITS, 8, payload bits per frame, legal 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2
FIFO_DEPTH, 4, input FIFO entries, power of 2, >= 2

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  reset, asynchronous, active-high
din  input  DATA_BITS  payload word, LSB transmitted first
din_valid  input  1  din holds a word to enqueue
din_ready  output  1  FIFO can accept; high when FIFO not full
tx  output  1  serial line, registered, idles high
busy  output  1  high while a frame is on the line (START..last STOP)
fifo_count  output  $clog2(FIFO_DEPTH)+1  words currently queued (excludes the frame being sent)

Behaviour:
- Reset (async assert, sync-safe release): tx=1, busy=0, FIFO flushed, fifo_count=0, din_ready=1, state=IDLE, baud counter=0, bit index=0. Reset mid-frame aborts the frame; tx returns high immediately on assertion.
- Push: on an edge with din_valid && din_ready, din is written and fifo_count increments. Words offered while din_ready=0 are not accepted; the source holds them.
- Pop occurs only on the IDLE->START or STOP->START transition. The popped word is latched into a shift register. Push and pop on the same edge leave fifo_count unchanged.
- din_ready = (fifo_count != FIFO_DEPTH), combinational from the count.
- States: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx=1. If fifo_count != 0, pop and go to START on the next edge.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: tx = shift[0] for CLKS_PER_BIT cycles per bit, DATA_BITS bits, LSB first. After the last bit go to PARITY if PARITY != 0, else STOP.
  - PARITY: tx = XOR of payload (even) or its inverse (odd) for CLKS_PER_BIT cycles, then STOP.
  - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. At the end, go to START with a pop if the FIFO is non-empty (zero gap); otherwise go to IDLE.
- Parity is computed over the latched word, so later pushes cannot corrupt it.
- Baud counter runs 0..CLKS_PER_BIT-1, resets on every bit boundary and every state change. Every bit is exactly CLKS_PER_BIT cycles wide.
- Frame length = (1 + DATA_BITS + (PARITY != 0) + STOP_BITS) * CLKS_PER_BIT cycles.
- Latency: a word pushed into an empty FIFO while IDLE produces tx falling 2 edges after the push edge (edge 1: push; edge 2: pop and START, tx registered low).
- busy is high from the START entry edge through the last STOP cycle. It stays high across back-to-back frames.
- Unused din bits above DATA_BITS do not exist; no truncation.

Test Plan:
1. CLK_FREQ=16, BAUD=1 (16 clk/bit), 8N1, push 0x55 -> tx low 2 edges after push, then 1,0,1,0,1,0,1,0 at 16-cycle spacing, stop high, busy falls after 160 cycles of frame.
2. DATA_BITS=7, PARITY=2, STOP_BITS=2, push 0x07 -> 7 data bits 1,1,1,0,0,0,0; parity bit=1; stop high 32 cycles; frame length 176 cycles. Repeat with PARITY=1 -> parity bit=0.
3. 8N1, push 0xA1, 0x3C, 0xFF on consecutive edges -> three frames with tx start bit immediately after each stop bit, busy high continuously, fifo_count sequence 1,2,(pop)...0.
4. FIFO_DEPTH=4, hold din_valid with 6 words while the first frame is active -> first word popped, next 4 accepted, din_ready=0 with fifo_count=4, sixth word held until the next pop, all 6 emitted in order.
5. Assert rst mid-DATA of 0x81 with 2 words queued -> tx=1 asynchronously, busy=0, fifo_count=0; after release, no frame emitted until a new push.
6. PARITY=0, DATA_BITS=9, push 9'h1AA -> 9 data bits LSB first, no parity slot, stop immediately after bit 8.
